// File: rtl/tte_hash_table_pkg.sv
// Shared widths, FSM encodings and entry layout for the TTE flow hash table.
// Each entry is {valid, flow}, with valid in the MSB.
package tte_hash_table_pkg;

  localparam int unsigned FLOW_W    = 120;
  localparam int unsigned HASH_W    = 10;
  localparam int unsigned DEPTH     = 1 << HASH_W;
  localparam int unsigned ENTRY_W   = FLOW_W + 1;
  localparam int unsigned VALID_BIT = ENTRY_W - 1;

  localparam logic [1:0] SWEEP = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // The sweep counter is one bit wider than the index, so the terminal compare never wraps.
  localparam logic [HASH_W:0] SWEEP_LAST = (HASH_W + 1)'(DEPTH - 1);

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t mk_entry(input logic valid, input logic [FLOW_W-1:0] key);
    return {valid, key};
  endfunction

endpackage

// File: rtl/tte_hash_table_ram.sv
// Simple dual-port RAM: one write port, one read port, read-first, 1-cycle registered read.
// The array has no reset; the table's power-up sweep initialises it.
module tte_hash_table_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrW;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  // The read samples the old word when both ports hit the same address.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/tte_hash_table.sv
// TTE flow hash table: one flow key per bucket. It has a clear-sweep FSM with a req/ack
// handshake, prioritised writes, and a 2-cycle exact-match lookup pipeline.
module tte_hash_table
  import tte_hash_table_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [FLOW_W-1:0] flow,
  input  logic [HASH_W-1:0] hash,
  input  logic              hash_update,
  input  logic              hash_clear,
  input  logic              ttehash_req,
  output logic              ttehash_ack,
  input  logic              lk_valid,
  input  logic [HASH_W-1:0] lk_hash,
  input  logic [FLOW_W-1:0] lk_flow,
  output logic              lk_done,
  output logic              lk_hit,
  output logic              busy,
  output logic              wr_drop
);

  logic [1:0]        state_q, state_d;
  logic [HASH_W:0]   sweep_addr_q, sweep_addr_d;
  logic              sweep_req_q, sweep_req_d;
  logic              wr_drop_q, wr_drop_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_busy_q, s1_busy_d;
  logic [FLOW_W-1:0] s1_flow_q, s1_flow_d;
  logic              lk_done_q, lk_done_d;
  logic              lk_hit_q, lk_hit_d;

  logic              sweeping;
  logic              ram_we;
  logic [HASH_W-1:0] ram_waddr;
  entry_t            ram_wdata;
  entry_t            rd_entry;

  assign sweeping = (state_q == SWEEP);

  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    sweep_req_d  = sweep_req_q;
    unique case (state_q)
      SWEEP: begin
        if (sweep_addr_q == SWEEP_LAST) begin
          state_d = sweep_req_q ? DONE : IDLE;
        end else begin
          sweep_addr_d = sweep_addr_q + (HASH_W + 1)'(1);
        end
      end
      IDLE: begin
        if (ttehash_req) begin
          sweep_addr_d = '0;
          sweep_req_d  = 1'b1;
          state_d      = SWEEP;
        end
      end
      // Ack stays up until req drops, so a still-high req cannot re-trigger a sweep.
      DONE: begin
        if (!ttehash_req) begin
          sweep_req_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        sweep_addr_d = '0;
        state_d      = SWEEP;
      end
    endcase
  end

  // The write port priority is sweep, then clear, then update.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = hash;
    ram_wdata = '0;
    if (sweeping) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_addr_q[HASH_W-1:0];
    end else if (hash_clear) begin
      ram_we    = 1'b1;
    end else if (hash_update) begin
      ram_we    = 1'b1;
      ram_wdata = mk_entry(1'b1, flow);
    end
    wr_drop_d = sweeping && (hash_update || hash_clear);
  end

  tte_hash_table_ram #(
    .Width (ENTRY_W),
    .AddrW (HASH_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (lk_hash),
    .rdata_o (rd_entry)
  );

  // Lookups launched during a sweep read stale data, so they are forced to miss.
  always_comb begin
    s1_valid_d = lk_valid;
    s1_busy_d  = sweeping;
    s1_flow_d  = lk_flow;
    lk_done_d  = s1_valid_q;
    lk_hit_d   = s1_valid_q && !s1_busy_q && rd_entry[VALID_BIT] &&
                 (rd_entry[FLOW_W-1:0] == s1_flow_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= SWEEP;
      sweep_addr_q <= '0;
      sweep_req_q  <= 1'b0;
      wr_drop_q    <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_busy_q    <= 1'b0;
      s1_flow_q    <= '0;
      lk_done_q    <= 1'b0;
      lk_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
      sweep_req_q  <= sweep_req_d;
      wr_drop_q    <= wr_drop_d;
      s1_valid_q   <= s1_valid_d;
      s1_busy_q    <= s1_busy_d;
      s1_flow_q    <= s1_flow_d;
      lk_done_q    <= lk_done_d;
      lk_hit_q     <= lk_hit_d;
    end
  end

  assign ttehash_ack = (state_q == DONE);
  assign busy        = sweeping;
  assign wr_drop     = wr_drop_q;
  assign lk_done     = lk_done_q;
  assign lk_hit      = lk_hit_q;

endmodule

// File: tb/tb_tte_hash_table.sv
// Directed self-checking bench for tte_hash_table: sweeps, the handshake, writes, lookups
// and resets, with hand-computed expected values.
module tb_tte_hash_table;
  import tte_hash_table_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic [FLOW_W-1:0] flow;
  logic [HASH_W-1:0] hash;
  logic              hash_update;
  logic              hash_clear;
  logic              ttehash_req;
  logic              ttehash_ack;
  logic              lk_valid;
  logic [HASH_W-1:0] lk_hash;
  logic [FLOW_W-1:0] lk_flow;
  logic              lk_done;
  logic              lk_hit;
  logic              busy;
  logic              wr_drop;

  int n_checks = 0;
  int n_fails  = 0;
  int busy_cnt = 0;
  int ack_cnt  = 0;

  logic [FLOW_W-1:0] key_a;
  logic [FLOW_W-1:0] key_b;
  logic [FLOW_W-1:0] key_c;
  logic [FLOW_W-1:0] bb_keys [4];
  logic [3:0]        bb_exp;

  tte_hash_table dut (
    .clk         (clk),
    .rstn        (rstn),
    .flow        (flow),
    .hash        (hash),
    .hash_update (hash_update),
    .hash_clear  (hash_clear),
    .ttehash_req (ttehash_req),
    .ttehash_ack (ttehash_ack),
    .lk_valid    (lk_valid),
    .lk_hash     (lk_hash),
    .lk_flow     (lk_flow),
    .lk_done     (lk_done),
    .lk_hit      (lk_hit),
    .busy        (busy),
    .wr_drop     (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts busy/ack as seen during the cycle that ends at this edge; samples 1 time unit after it.
  task automatic tick();
    if (busy) busy_cnt++;
    if (ttehash_ack) ack_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [HASH_W-1:0] h, input logic [FLOW_W-1:0] k);
    hash        = h;
    flow        = k;
    hash_update = 1'b1;
    tick();
    hash_update = 1'b0;
  endtask

  task automatic do_clear(input logic [HASH_W-1:0] h);
    hash       = h;
    hash_clear = 1'b1;
    tick();
    hash_clear = 1'b0;
  endtask

  task automatic do_lookup(input string tag, input logic [HASH_W-1:0] h,
                           input logic [FLOW_W-1:0] k, input logic exp_hit);
    lk_valid = 1'b1;
    lk_hash  = h;
    lk_flow  = k;
    tick();
    lk_valid = 1'b0;
    tick();
    check_val({tag, "_done"}, lk_done, 1'b1);
    check_val({tag, "_hit"}, lk_hit, exp_hit);
  endtask

  task automatic wait_sweep_end();
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    check_val("sweep_ends", busy, 1'b0);
  endtask

  initial begin
    key_a = {15{8'hA5}};
    key_b = 120'h123456789ABCDEF0123456789ABCDE;
    key_c = ~key_b;
    rstn        = 1'b0;
    flow        = '0;
    hash        = '0;
    hash_update = 1'b0;
    hash_clear  = 1'b0;
    ttehash_req = 1'b0;
    lk_valid    = 1'b0;
    lk_hash     = '0;
    lk_flow     = '0;
    repeat (3) @(posedge clk);
    #1;

    check_val("rst_busy", busy, 1'b1);
    check_val("rst_ack", ttehash_ack, 1'b0);
    check_val("rst_lk_done", lk_done, 1'b0);
    check_val("rst_lk_hit", lk_hit, 1'b0);
    check_val("rst_wr_drop", wr_drop, 1'b0);

    // The power-up sweep runs with no ack.
    rstn     = 1'b1;
    busy_cnt = 0;
    ack_cnt  = 0;
    wait_sweep_end();
    check_val("pwr_sweep_len", busy_cnt, 1024);
    check_val("pwr_no_ack", ack_cnt, 0);
    do_lookup("pwr_h0", 10'h000, key_a, 1'b0);
    do_lookup("pwr_h3ff", 10'h3FF, key_a, 1'b0);

    do_update(10'h155, key_a);
    tick();
    do_lookup("upd", 10'h155, key_a, 1'b1);
    do_lookup("flip", 10'h155, key_a ^ 120'd1, 1'b0);
    do_clear(10'h155);
    do_lookup("clr", 10'h155, key_a, 1'b0);

    // Clear takes precedence over a simultaneous update.
    hash        = 10'h020;
    flow        = key_b;
    hash_update = 1'b1;
    hash_clear  = 1'b1;
    tick();
    hash_update = 1'b0;
    hash_clear  = 1'b0;
    do_lookup("clr_upd", 10'h020, key_b, 1'b0);

    // A lookup in the same cycle as the write reads the old entry; the next cycle reads the new one.
    hash        = 10'h3FF;
    flow        = key_c;
    hash_update = 1'b1;
    lk_valid    = 1'b1;
    lk_hash     = 10'h3FF;
    lk_flow     = key_c;
    tick();
    hash_update = 1'b0;
    tick();
    lk_valid = 1'b0;
    check_val("rf_same_done", lk_done, 1'b1);
    check_val("rf_same_hit", lk_hit, 1'b0);
    tick();
    check_val("rf_next_done", lk_done, 1'b1);
    check_val("rf_next_hit", lk_hit, 1'b1);

    // Back-to-back lookups: the expected hit pattern is 1,0,1,0, in issue order.
    do_update(10'h100, key_a);
    do_update(10'h102, key_c);
    bb_keys[0] = key_a;
    bb_keys[1] = key_a;
    bb_keys[2] = key_c;
    bb_keys[3] = key_c;
    bb_exp     = 4'b0101;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        lk_valid = 1'b1;
        lk_hash  = 10'h100 + HASH_W'(i);
        lk_flow  = bb_keys[i];
      end else begin
        lk_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 4) begin
        check_val($sformatf("b2b%0d_done", i - 1), lk_done, 1'b1);
        check_val($sformatf("b2b%0d_hit", i - 1), lk_hit, bb_exp[i-1]);
      end else if (i == 5) begin
        check_val("b2b_tail_done", lk_done, 1'b0);
      end
    end

    do_update(10'h2AA, key_b);
    do_lookup("pre_sweep", 10'h2AA, key_b, 1'b1);

    // Full clear through the req/ack handshake.
    busy_cnt    = 0;
    ack_cnt     = 0;
    ttehash_req = 1'b1;
    tick();
    check_val("hs_busy", busy, 1'b1);
    hash        = 10'h0AB;
    flow        = key_b;
    hash_update = 1'b1;
    tick();
    hash_update = 1'b0;
    check_val("drop_pulse", wr_drop, 1'b1);
    tick();
    check_val("drop_end", wr_drop, 1'b0);
    do_lookup("lk_busy", 10'h2AA, key_b, 1'b0);
    wait_sweep_end();
    check_val("hs_sweep_len", busy_cnt, 1024);
    check_val("hs_ack", ttehash_ack, 1'b1);
    repeat (5) tick();
    check_val("hs_ack_hold", ttehash_ack, 1'b1);
    check_val("hs_no_resweep", busy, 1'b0);
    ttehash_req = 1'b0;
    tick();
    check_val("hs_ack_drop", ttehash_ack, 1'b0);
    repeat (3) tick();
    check_val("hs_idle", busy, 1'b0);
    do_lookup("gone_100", 10'h100, key_a, 1'b0);
    do_lookup("gone_102", 10'h102, key_c, 1'b0);
    do_lookup("gone_3ff", 10'h3FF, key_c, 1'b0);
    do_lookup("gone_2aa", 10'h2AA, key_b, 1'b0);
    do_lookup("gone_0ab", 10'h0AB, key_b, 1'b0);

    // Reset at sweep address 500 with a lookup still in flight.
    ttehash_req = 1'b1;
    tick();
    repeat (499) tick();
    lk_valid = 1'b1;
    lk_hash  = 10'h2AA;
    lk_flow  = key_b;
    tick();
    lk_valid    = 1'b0;
    rstn        = 1'b0;
    ttehash_req = 1'b0;
    #1;
    check_val("mid_rst_ack", ttehash_ack, 1'b0);
    check_val("mid_rst_busy", busy, 1'b1);
    check_val("mid_rst_done", lk_done, 1'b0);
    tick();
    rstn     = 1'b1;
    busy_cnt = 0;
    ack_cnt  = 0;
    tick();
    check_val("mid_rst_flush", lk_done, 1'b0);
    wait_sweep_end();
    check_val("mid_rst_sweep_len", busy_cnt, 1024);
    check_val("mid_rst_no_ack", ack_cnt, 0);

    // Reset while acking drops ack at once.
    ttehash_req = 1'b1;
    tick();
    wait_sweep_end();
    check_val("done_ack", ttehash_ack, 1'b1);
    rstn = 1'b0;
    #1;
    check_val("done_rst_ack", ttehash_ack, 1'b0);
    check_val("done_rst_busy", busy, 1'b1);
    ttehash_req = 1'b0;
    tick();
    rstn     = 1'b1;
    busy_cnt = 0;
    wait_sweep_end();
    check_val("done_rst_sweep_len", busy_cnt, 1024);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
